mamba_tile_scheduler: RTL and testbench
=======================================

Name: mamba_tile_scheduler

Overview:
- Sequences the MAC → bias → FIFO → sigmoid → join → EW tile pipeline for a run of tokens.
- Issues one tile-start handshake per 4-lane tile: D/TILE_SIZE tiles per token, cfg_n_tokens tokens per run.
- Limits tiles in flight with a credit counter that is decremented by EW-output handshakes.
- Drains the pipeline, then signals completion.
- Sits between the host/config layer and the `s_axis_TVALID/TREADY` tile-start port of the MAC top.

Parameters:
- TILE_SIZE, 4, lanes per tile.
- D, 256, state/channel length; N_TILES = D/TILE_SIZE (localparam, 64 at defaults); D must be a multiple of TILE_SIZE.
- MAX_OUTSTANDING, 4, maximum tiles issued but not yet retired at EW output; must be ≥1.
- TOK_W, 16, width of the token count.
- GAP_W, 8, width of the minimum inter-issue gap.
- TI_W, $clog2(N_TILES), tile index width (localparam).
- OC_W, $clog2(MAX_OUTSTANDING+1), outstanding-count width (localparam).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_start  in  1  run start pulse; accepted only in IDLE.
- cfg_n_tokens  in  TOK_W  tokens in the run; latched on an accepted start.
- cfg_gap  in  GAP_W  minimum idle cycles between tile issues; latched on an accepted start.
- busy  out  1  high in ISSUE, DRAIN and DONE.
- done  out  1  one-cycle pulse at run completion.
- tile_TVALID  out  1  tile-start request; drives MAC s_axis_TVALID.
- tile_TREADY  in  1  from MAC s_axis_TREADY.
- tile_idx  out  TI_W  index of the tile being requested.
- tok_idx  out  TOK_W  index of the token being requested.
- ew_valid  in  1  monitor tap of s_out_valid.
- ew_ready  in  1  monitor tap of s_out_ready.
- outstanding  out  OC_W  tiles currently in flight.
- err_underflow  out  1  sticky: EW handshake seen with outstanding==0.

Behaviour:
- **Clock and reset:** one clock domain. Reset is asynchronous and active-low.
- **Reset values:** state=IDLE; all outputs 0; gap_cnt=0; latched config=0.
- **Handshakes:** issue_fire = tile_TVALID & tile_TREADY; retire = ew_valid & ew_ready.
- **IDLE:**
  - cfg_start with cfg_n_tokens>0: latch config, clear tile_idx/tok_idx/err_underflow, next state ISSUE. busy rises on the next cycle.
  - cfg_start with cfg_n_tokens==0: go to DONE; done pulses the next cycle, with no TVALID.
- **ISSUE:**
  - tile_TVALID = (gap_cnt==0) & (outstanding<MAX_OUTSTANDING).
  - Once asserted, TVALID, tile_idx and tok_idx stay stable until issue_fire. Credits can only grow while waiting, so this holds by construction.
  - First TVALID appears one cycle after the start is accepted; no gap applies before the first tile.
  - On issue_fire:
    - gap_cnt ← cfg_gap.
    - tile_idx increments, wrapping N_TILES-1 → 0 with tok_idx+1.
    - If this was the last tile of the last token, next state is DRAIN.
  - gap_cnt decrements each cycle while nonzero. cfg_gap=0 gives back-to-back issue; fire cycles are separated by cfg_gap+1 cycles minimum.
- **DRAIN:** TVALID=0; when outstanding==0, next state DONE.
- **DONE:** done=1 for exactly one cycle, then IDLE; busy drops with it.
- **Credit counter:**
  - issue_fire only: +1. retire only: −1. Both in the same cycle: unchanged.
  - retire while outstanding==0 (and no simultaneous issue): counter holds at 0 and err_underflow is set. err_underflow clears only on the next accepted cfg_start or on reset.
  - Retires are counted in every state, including IDLE.
- **Ignored inputs:** cfg_start outside IDLE is ignored; config changes mid-run have no effect.
- **Reset mid-run:** everything returns to reset values immediately and TVALID drops asynchronously. The downstream pipeline is reset by the same rst_n.
- **Total issues per run:** exactly cfg_n_tokens·N_TILES.

Decomposition:
- **Package mamba_sched_pkg:** state enum {IDLE, ISSUE, DRAIN, DONE} and a function n_tiles(D, TILE_SIZE).
- **Sub-module tile_credit_counter:** inc, dec, count, underflow outputs; parameter MAX. It is reusable for other in-flight-limited stages.

Test Plan:
- **Basic run:** n_tokens=1, gap=0, TREADY=1, EW returns each tile 5 cycles after issue → 64 fires with tile_idx 0..63, outstanding never exceeds 4, done one cycle after the 64th retire drives outstanding to 0.
- **Credit stall:** MAX_OUTSTANDING=4, EW held off for 50 cycles → TVALID drops after 4 fires, outstanding=4. Releasing one retire → exactly one further fire.
- **Backpressure hold:** TREADY low for 7 cycles at tile_idx=10 → TVALID, tile_idx=10 and tok_idx stable throughout; no duplicate or skipped index.
- **Gap and wrap:** gap=3, n_tokens=2 → fires ≥4 cycles apart; tile_idx wraps 63→0 with tok_idx 0→1; 128 total fires.
- **Corner cases:** n_tokens=0 → done pulse the cycle after start, zero fires. A retire with outstanding=0 → err_underflow=1, count stays 0, bit clears on the next start. Simultaneous fire+retire → count unchanged.
- **Reset mid-run:** rst_n low at tile 20 → TVALID/busy/outstanding at 0 immediately. A new start afterwards begins at tile_idx 0.

Source files
------------

// File: rtl/mamba_tile_scheduler_pkg.sv
// Shared types and helpers for the Mamba tile scheduler.
package mamba_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  function automatic int n_tiles(input int d, input int tile_size);
    return d / tile_size;
  endfunction

endpackage

// File: rtl/tile_credit_counter.sv
// In-flight counter: +1 on inc, -1 on dec, unchanged on both; flags a dec seen while empty.
module tile_credit_counter #(
  parameter int MAX = 4,
  localparam int CW = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          underflow
);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    underflow  = 1'b0;
    unique case ({inc, dec})
      2'b10: begin
        if (count_reg != CW'(MAX)) count_next = count_reg + CW'(1);
      end
      2'b01: begin
        // An empty counter holds at zero rather than wrapping.
        if (count_reg == '0) underflow = 1'b1;
        else                 count_next = count_reg - CW'(1);
      end
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_reg <= '0;
    else        count_reg <= count_next;
  end

  assign count = count_reg;

endmodule

// File: rtl/mamba_tile_scheduler.sv
// Issues one tile-start request per 4-lane tile for a run of tokens,
// throttled by a minimum gap and by the number of tiles still in flight.
module mamba_tile_scheduler
  import mamba_sched_pkg::*;
#(
  parameter int TILE_SIZE       = 4,
  parameter int D               = 256,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TOK_W           = 16,
  parameter int GAP_W           = 8,
  localparam int N_TILES        = n_tiles(D, TILE_SIZE),
  localparam int TI_W           = $clog2(N_TILES),
  localparam int OC_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [TOK_W-1:0] cfg_n_tokens,
  input  logic [GAP_W-1:0] cfg_gap,
  output logic             busy,
  output logic             done,
  output logic             tile_TVALID,
  input  logic             tile_TREADY,
  output logic [TI_W-1:0]  tile_idx,
  output logic [TOK_W-1:0] tok_idx,
  input  logic             ew_valid,
  input  logic             ew_ready,
  output logic [OC_W-1:0]  outstanding,
  output logic             err_underflow
);

  sched_state_t     state_reg, state_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic [TOK_W-1:0] n_tokens_reg, n_tokens_next;
  logic [TOK_W-1:0] tok_idx_reg, tok_idx_next;
  logic [TI_W-1:0]  tile_idx_reg, tile_idx_next;
  logic             err_reg, err_next;

  logic issue_fire;
  logic retire;
  logic underflow;
  logic credit_ok;
  logic last_col;
  logic last_tile;

  tile_credit_counter #(
    .MAX (MAX_OUTSTANDING)
  ) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (issue_fire),
    .dec       (retire),
    .count     (outstanding),
    .underflow (underflow)
  );

  // Request depends only on registered state, so it is stable until it fires:
  // the gap counter is already zero and credits can only grow while waiting.
  assign credit_ok   = outstanding < OC_W'(MAX_OUTSTANDING);
  assign tile_TVALID = (state_reg == ISSUE) && (gap_cnt_reg == '0) && credit_ok;
  assign issue_fire  = tile_TVALID & tile_TREADY;
  assign retire      = ew_valid & ew_ready;

  assign last_col  = tile_idx_reg == TI_W'(N_TILES - 1);
  assign last_tile = last_col && (tok_idx_reg == n_tokens_reg - TOK_W'(1));

  always_comb begin
    state_next    = state_reg;
    gap_next      = gap_reg;
    n_tokens_next = n_tokens_reg;
    tile_idx_next = tile_idx_reg;
    tok_idx_next  = tok_idx_reg;
    gap_cnt_next  = (gap_cnt_reg != '0) ? gap_cnt_reg - GAP_W'(1) : '0;
    err_next      = err_reg | underflow;

    unique case (state_reg)
      IDLE: begin
        if (cfg_start) begin
          n_tokens_next = cfg_n_tokens;
          gap_next      = cfg_gap;
          tile_idx_next = '0;
          tok_idx_next  = '0;
          gap_cnt_next  = '0;
          err_next      = underflow;
          state_next    = (cfg_n_tokens == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (issue_fire) begin
          gap_cnt_next = gap_reg;
          if (last_col) begin
            tile_idx_next = '0;
            tok_idx_next  = tok_idx_reg + TOK_W'(1);
          end else begin
            tile_idx_next = tile_idx_reg + TI_W'(1);
          end
          if (last_tile) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding == '0) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gap_cnt_reg  <= '0;
      gap_reg      <= '0;
      n_tokens_reg <= '0;
      tile_idx_reg <= '0;
      tok_idx_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gap_cnt_reg  <= gap_cnt_next;
      gap_reg      <= gap_next;
      n_tokens_reg <= n_tokens_next;
      tile_idx_reg <= tile_idx_next;
      tok_idx_reg  <= tok_idx_next;
      err_reg      <= err_next;
    end
  end

  assign busy          = state_reg != IDLE;
  assign done          = state_reg == DONE;
  assign tile_idx      = tile_idx_reg;
  assign tok_idx       = tok_idx_reg;
  assign err_underflow = err_reg;

endmodule

// File: tb/tb_mamba_tile_scheduler.sv
// Directed bench: table of full runs plus hand-written stall, backpressure,
// underflow, zero-token and mid-run reset sequences.
module tb_mamba_tile_scheduler;

  logic        clk;
  logic        rst_n;
  logic        cfg_start;
  logic [15:0] cfg_n_tokens;
  logic [7:0]  cfg_gap;
  logic        busy;
  logic        done;
  logic        tile_TVALID;
  logic        tile_TREADY;
  logic [5:0]  tile_idx;
  logic [15:0] tok_idx;
  logic        ew_valid;
  logic        ew_ready;
  logic [2:0]  outstanding;
  logic        err_underflow;

  mamba_tile_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_n_tokens  (cfg_n_tokens),
    .cfg_gap       (cfg_gap),
    .busy          (busy),
    .done          (done),
    .tile_TVALID   (tile_TVALID),
    .tile_TREADY   (tile_TREADY),
    .tile_idx      (tile_idx),
    .tok_idx       (tok_idx),
    .ew_valid      (ew_valid),
    .ew_ready      (ew_ready),
    .outstanding   (outstanding),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n_tok;
    int gap;
    int lat;
    int exp_fires;
    int exp_max;
    int exp_space;
  } vec_t;

  vec_t vecs[4];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int fires, exp_tile, exp_tok, seq_err, max_out;
  int last_fire, min_space, done_cnt, done_cyc, last_retire;
  int latency = 5;
  int due_q[$];
  bit ew_allow = 1'b1;
  bit force_retire = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic reset_stats();
    fires = 0; exp_tile = 0; exp_tok = 0; seq_err = 0; max_out = 0;
    last_fire = -1; min_space = 1000; done_cnt = 0; done_cyc = -1; last_retire = -1;
    due_q.delete();
  endtask

  // One clock cycle: called at posedge+1, drives EW, samples on negedge.
  task automatic cycle();
    ew_valid = force_retire || (ew_allow && due_q.size() > 0 && due_q[0] <= cyc);
    ew_ready = ew_valid;
    @(negedge clk);
    if (int'(outstanding) > max_out) max_out = int'(outstanding);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (tile_TVALID && tile_TREADY) begin
      if (int'(tile_idx) != exp_tile || int'(tok_idx) != exp_tok) seq_err++;
      if (last_fire >= 0 && cyc - last_fire < min_space) min_space = cyc - last_fire;
      last_fire = cyc;
      fires++;
      due_q.push_back(cyc + latency);
      exp_tile++;
      if (exp_tile == 64) begin
        exp_tile = 0;
        exp_tok++;
      end
    end
    if (ew_valid && ew_ready) begin
      if (!force_retire && due_q.size() > 0) void'(due_q.pop_front());
      last_retire = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_run(input int n, input int gap);
    cfg_n_tokens = 16'(n);
    cfg_gap      = 8'(gap);
    cfg_start    = 1'b1;
    cycle();
    cfg_start    = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int g;
    g = 0;
    while (done_cnt == 0 && g < budget) begin
      cycle();
      g++;
    end
    check("done_seen", int'(done_cnt > 0), 1);
    cycle();
  endtask

  task automatic run_until_fires(input int n, input int budget);
    int g;
    g = 0;
    while (fires < n && g < budget) begin
      cycle();
      g++;
    end
    check("fire_target", fires, n);
  endtask

  initial begin
    int bad;
    vecs[0] = '{n_tok: 1, gap: 0, lat: 5, exp_fires: 64,  exp_max: 4, exp_space: 1};
    vecs[1] = '{n_tok: 2, gap: 3, lat: 5, exp_fires: 128, exp_max: 2, exp_space: 4};
    vecs[2] = '{n_tok: 1, gap: 1, lat: 1, exp_fires: 64,  exp_max: 1, exp_space: 2};
    vecs[3] = '{n_tok: 3, gap: 0, lat: 2, exp_fires: 192, exp_max: 2, exp_space: 1};

    rst_n = 1'b0; cfg_start = 1'b0; cfg_n_tokens = '0; cfg_gap = '0;
    tile_TREADY = 1'b1; ew_valid = 1'b0; ew_ready = 1'b0;
    reset_stats();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tvalid", int'(tile_TVALID), 0);
    check("rst_outstanding", int'(outstanding), 0);
    check("rst_err", int'(err_underflow), 0);
    check("rst_tile_idx", int'(tile_idx), 0);

    // Table-driven full runs.
    for (int i = 0; i < 4; i++) begin
      reset_stats();
      latency = vecs[i].lat;
      ew_allow = 1'b1;
      tile_TREADY = 1'b1;
      start_run(vecs[i].n_tok, vecs[i].gap);
      run_until_done(20000);
      $display("vector %0d: n_tok=%0d gap=%0d lat=%0d fires=%0d max_out=%0d min_space=%0d",
               i, vecs[i].n_tok, vecs[i].gap, vecs[i].lat, fires, max_out, min_space);
      check($sformatf("v%0d_fires", i), fires, vecs[i].exp_fires);
      check($sformatf("v%0d_sequence", i), seq_err, 0);
      check($sformatf("v%0d_max_out", i), max_out, vecs[i].exp_max);
      check($sformatf("v%0d_min_space", i), min_space, vecs[i].exp_space);
      check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      check($sformatf("v%0d_done_latency", i), done_cyc - last_retire, 2);
      check($sformatf("v%0d_busy_end", i), int'(busy), 0);
      check($sformatf("v%0d_out_end", i), int'(outstanding), 0);
    end

    // Zero-token run.
    reset_stats();
    start_run(0, 0);
    check("zero_done", int'(done), 1);
    check("zero_busy", int'(busy), 1);
    check("zero_tvalid", int'(tile_TVALID), 0);
    cycle();
    check("zero_done_drop", int'(done), 0);
    check("zero_busy_drop", int'(busy), 0);
    check("zero_fires", fires, 0);
    $display("zero-token run: done pulses=%0d fires=%0d", done_cnt, fires);

    // Underflow in IDLE, cleared by the next start.
    reset_stats();
    force_retire = 1'b1;
    cycle();
    force_retire = 1'b0;
    check("uf_err_set", int'(err_underflow), 1);
    check("uf_count_zero", int'(outstanding), 0);
    latency = 3;
    start_run(1, 0);
    check("uf_err_clear", int'(err_underflow), 0);
    check("first_tvalid", int'(tile_TVALID), 1);
    check("first_tile_idx", int'(tile_idx), 0);
    run_until_done(2000);
    check("uf_run_fires", fires, 64);
    $display("underflow sequence: err cleared, run fires=%0d", fires);

    // Credit stall, single release, then reset mid-run.
    reset_stats();
    latency = 5;
    ew_allow = 1'b0;
    start_run(1, 0);
    repeat (50) cycle();
    check("stall_fires", fires, 4);
    check("stall_outstanding", int'(outstanding), 4);
    check("stall_tvalid", int'(tile_TVALID), 0);
    ew_allow = 1'b1;
    cycle();
    ew_allow = 1'b0;
    repeat (10) cycle();
    check("release_one_fire", fires, 5);
    $display("credit stall: fires after release=%0d", fires);
    ew_allow = 1'b1;
    run_until_fires(20, 500);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", int'(tile_TVALID), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_outstanding", int'(outstanding), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_stats();
    start_run(1, 0);
    check("post_rst_tile_idx", int'(tile_idx), 0);
    run_until_done(2000);
    check("post_rst_fires", fires, 64);
    check("post_rst_sequence", seq_err, 0);
    $display("reset mid-run: restarted run fires=%0d", fires);

    // Backpressure hold at tile 10, with ignored mid-run config changes.
    reset_stats();
    latency = 3;
    start_run(1, 0);
    run_until_fires(10, 200);
    tile_TREADY = 1'b0;
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      if (!tile_TVALID || int'(tile_idx) != 10 || int'(tok_idx) != 0) bad++;
      cfg_start = 1'b1; cfg_n_tokens = 16'd5; cfg_gap = 8'd9;
      cycle();
    end
    cfg_start = 1'b0;
    check("bp_hold_stable", bad, 0);
    check("bp_no_fire", fires, 10);
    tile_TREADY = 1'b1;
    run_until_done(2000);
    check("bp_fires", fires, 64);
    check("bp_sequence", seq_err, 0);
    $display("backpressure: stable violations=%0d total fires=%0d", bad, fires);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
